// File: rtl/ysyx_22050854_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// the NOP inserted on a misaligned fetch, and the default reset PC.
package ysyx_22050854_ifu_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_WAIT = 3'd2,
      S_HOLD = 3'd3,
      S_DROP = 3'd4
   } ifu_state_e;

   localparam logic [31:0] IFU_NOP_INST = 32'h00000013;
   localparam logic [31:0] IFU_RESET_PC = 32'h80000000;

endpackage

// File: rtl/ysyx_22050854_ifu_buf.sv
// Output holding register for the fetch unit: keeps {inst, pc, fault}
// stable towards decode. Clear has priority over load.
module ysyx_22050854_ifu_buf #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] inst_d,
   input  logic [ADDR_W-1:0] pc_d,
   input  logic              fault_d,
   output logic [DATA_W-1:0] inst_q,
   output logic [ADDR_W-1:0] pc_q,
   output logic              fault_q
);

   // Hold the last loaded instruction until cleared or reloaded
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         inst_q  <= '0;
         pc_q    <= '0;
         fault_q <= 1'b0;
      end else if (load) begin
         inst_q  <= inst_d;
         pc_q    <= pc_d;
         fault_q <= fault_d;
      end
   end

endmodule

// File: rtl/ysyx_22050854_ifu.sv
// Instruction fetch unit: accepts a fetch address, issues one outstanding
// request to instruction memory and presents {inst, pc} to decode.
// Optional feature macro: IFU_MISALIGN_EN (misaligned fetch -> NOP + fault).
module ysyx_22050854_ifu
   import ysyx_22050854_ifu_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFU_RESET_PC)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              pc_valid_i,
   output logic              pc_ready_o,
   input  logic              flush_i,
   output logic              imem_req_valid_o,
   input  logic              imem_req_ready_i,
   output logic [ADDR_W-1:0] imem_req_addr_o,
   input  logic              imem_resp_valid_i,
   input  logic [DATA_W-1:0] imem_resp_data_i,
   output logic              inst_valid_o,
   input  logic              inst_ready_i,
   output logic [DATA_W-1:0] inst_o,
   output logic [ADDR_W-1:0] inst_pc_o,
   output logic              inst_fault_o
);

   ifu_state_e        state_q;
   ifu_state_e        state_d;
   logic [ADDR_W-1:0] addr_q;
   logic              drop_q;
   logic              pc_fire;
   logic              pc_misalign;
   logic              buf_load;
   logic              buf_clear;
   logic [DATA_W-1:0] buf_inst_d;
   logic [ADDR_W-1:0] buf_pc_d;
   logic              buf_fault_d;

   // A new PC is taken in IDLE, or in HOLD when decode consumes the held inst
   assign pc_fire = pc_valid_i && !flush_i &&
                    ((state_q == S_IDLE) || ((state_q == S_HOLD) && inst_ready_i));

`ifdef IFU_MISALIGN_EN
   assign pc_misalign = (pc_i[1:0] != 2'b00);
`else
   assign pc_misalign = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (pc_fire) begin
               state_d = pc_misalign ? S_HOLD : S_REQ;
            end
         end
         S_REQ: begin
            // a flush seen at any point while requesting turns the accept into a drop
            if (imem_req_ready_i) begin
               state_d = (drop_q || flush_i) ? S_DROP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_resp_valid_i) begin
               state_d = flush_i ? S_IDLE : S_HOLD;
            end else if (flush_i) begin
               state_d = S_DROP;
            end
         end
         S_HOLD: begin
            if (flush_i) begin
               state_d = S_IDLE;
            end else if (inst_ready_i) begin
               if (pc_fire) begin
                  state_d = pc_misalign ? S_HOLD : S_REQ;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_DROP: begin
            if (imem_resp_valid_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs and holding-register controls
   always_comb begin
      pc_ready_o       = 1'b0;
      imem_req_valid_o = 1'b0;
      inst_valid_o     = 1'b0;
      buf_load         = 1'b0;
      buf_clear        = 1'b0;
      buf_inst_d       = imem_resp_data_i;
      buf_pc_d         = addr_q;
      buf_fault_d      = 1'b0;
      case (state_q)
         S_IDLE: pc_ready_o = 1'b1;
         S_REQ:  imem_req_valid_o = 1'b1;
         S_WAIT: buf_load = imem_resp_valid_i && !flush_i;
         S_HOLD: begin
            inst_valid_o = 1'b1;
            pc_ready_o   = inst_ready_i;
            buf_clear    = flush_i;
         end
         default: ;
      endcase
`ifdef IFU_MISALIGN_EN
      if (pc_fire && pc_misalign) begin
         buf_load    = 1'b1;
         buf_inst_d  = DATA_W'(IFU_NOP_INST);
         buf_pc_d    = pc_i;
         buf_fault_d = 1'b1;
      end
`endif
   end

   // Latched fetch address, presented to memory while requesting
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q <= RESET_PC;
      end else if (pc_fire) begin
         addr_q <= pc_i;
      end
   end

   // Sticky drop flag: remembers a flush that arrived while the request was unaccepted
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_q <= 1'b0;
      end else if ((state_q == S_REQ) && !imem_req_ready_i) begin
         drop_q <= drop_q || flush_i;
      end else begin
         drop_q <= 1'b0;
      end
   end

   assign imem_req_addr_o = addr_q;

   ysyx_22050854_ifu_buf #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .load    (buf_load),
      .clear   (buf_clear),
      .inst_d  (buf_inst_d),
      .pc_d    (buf_pc_d),
      .fault_d (buf_fault_d),
      .inst_q  (inst_o),
      .pc_q    (inst_pc_o),
      .fault_q (inst_fault_o)
   );

   a_req_hold : assert property (@(posedge clk) disable iff (rst)
      imem_req_valid_o && !imem_req_ready_i |=> imem_req_valid_o && $stable(imem_req_addr_o));

   a_inst_hold : assert property (@(posedge clk) disable iff (rst)
      inst_valid_o && !inst_ready_i && !flush_i |=>
         inst_valid_o && $stable(inst_o) && $stable(inst_pc_o));

endmodule

// File: tb/tb_ysyx_22050854_ifu.sv
// Self-checking bench for ysyx_22050854_ifu: a transaction-level model of
// fetch ownership checked every cycle, a latency-programmable memory
// responder, and directed scenarios with literal expectations.
module tb_ysyx_22050854_ifu;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc_i = '0;
   logic        pc_valid_i = 1'b0;
   logic        pc_ready_o;
   logic        flush_i = 1'b0;
   logic        imem_req_valid_o;
   logic        imem_req_ready_i = 1'b0;
   logic [31:0] imem_req_addr_o;
   logic        imem_resp_valid_i = 1'b0;
   logic [31:0] imem_resp_data_i = '0;
   logic        inst_valid_o;
   logic        inst_ready_i = 1'b0;
   logic [31:0] inst_o;
   logic [31:0] inst_pc_o;
   logic        inst_fault_o;

   int unsigned n_checks = 0;
   int unsigned n_err    = 0;

   always #5 clk = ~clk;

   ysyx_22050854_ifu #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .RESET_PC (32'h80000000)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .pc_i              (pc_i),
      .pc_valid_i        (pc_valid_i),
      .pc_ready_o        (pc_ready_o),
      .flush_i           (flush_i),
      .imem_req_valid_o  (imem_req_valid_o),
      .imem_req_ready_i  (imem_req_ready_i),
      .imem_req_addr_o   (imem_req_addr_o),
      .imem_resp_valid_i (imem_resp_valid_i),
      .imem_resp_data_i  (imem_resp_data_i),
      .inst_valid_o      (inst_valid_o),
      .inst_ready_i      (inst_ready_i),
      .inst_o            (inst_o),
      .inst_pc_o         (inst_pc_o),
      .inst_fault_o      (inst_fault_o)
   );

   // Memory contents: 0x80000000 holds 0x00100093, each word offset adds to it
   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return a - 32'h80000000 + 32'h00100093;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- memory responder ----------------
   int unsigned mem_lat   = 1;
   int unsigned req_count = 0;
   longint      cyc       = 0;
   longint      resp_cyc  = 0;
   bit          mem_busy  = 1'b0;
   bit          resp_next = 1'b0;
   logic [31:0] mem_addr  = '0;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         mem_busy  = 1'b0;
         resp_next = 1'b0;
      end else begin
         if (imem_resp_valid_i) mem_busy = 1'b0;
         if (imem_req_valid_o && imem_req_ready_i) begin
            check("one_outstanding", {31'd0, mem_busy}, 32'd0);
            mem_busy = 1'b1;
            mem_addr = imem_req_addr_o;
            resp_cyc = cyc + longint'(mem_lat);
            req_count++;
         end
         resp_next = mem_busy && (cyc + 1 == resp_cyc);
      end
   end

   always @(posedge clk) begin
      #1;
      imem_resp_valid_i = resp_next;
      imem_resp_data_i  = resp_next ? mem_fn(mem_addr) : 32'hdeadbeef;
   end

   // ---------------- ownership model + per-cycle compare ----------------
   // owed: a fetch address was taken but memory has not accepted its request
   // out : memory holds an accepted request whose response is still due
   // alive/seen: the newest fetch is still wanted / its instruction is back
   bit          m_owed = 1'b0, m_out = 1'b0, m_alive = 1'b0, m_seen = 1'b0, m_fault = 1'b0;
   logic [31:0] m_owed_addr = '0, m_out_addr = '0, m_pc = '0, m_data = '0;
   int unsigned m_id = 0, m_req_id = 0, m_out_id = 0;

   always @(negedge clk) begin
      bit exp_valid, exp_pc_ready, pc_hs, req_hs, mis;
      if (rst) begin
         m_owed = 1'b0; m_out = 1'b0; m_alive = 1'b0; m_seen = 1'b0; m_fault = 1'b0;
      end else begin
         exp_valid    = m_alive && m_seen;
         exp_pc_ready = (!m_owed && !m_out && !m_alive) || (exp_valid && inst_ready_i);
         check("m_req_valid", {31'd0, imem_req_valid_o}, {31'd0, m_owed});
         if (m_owed) check("m_req_addr", imem_req_addr_o, m_owed_addr);
         check("m_pc_ready", {31'd0, pc_ready_o}, {31'd0, exp_pc_ready});
         check("m_inst_valid", {31'd0, inst_valid_o}, {31'd0, exp_valid});
         if (exp_valid) begin
            check("m_inst", inst_o, m_data);
            check("m_inst_pc", inst_pc_o, m_pc);
            check("m_fault", {31'd0, inst_fault_o}, {31'd0, m_fault});
         end
         // advance to the state after the coming edge
         pc_hs  = pc_valid_i && exp_pc_ready && !flush_i;
         req_hs = m_owed && imem_req_ready_i;
         if (imem_resp_valid_i && m_out) begin
            m_out = 1'b0;
            if (m_out_id == m_id && m_alive && !flush_i) begin
               m_seen  = 1'b1;
               m_data  = mem_fn(m_out_addr);
               m_fault = 1'b0;
            end
         end
         if (flush_i || (exp_valid && inst_ready_i)) m_alive = 1'b0;
         if (req_hs) begin
            m_owed     = 1'b0;
            m_out      = 1'b1;
            m_out_id   = m_req_id;
            m_out_addr = m_owed_addr;
         end
         if (pc_hs) begin
            m_id++;
            m_alive = 1'b1;
            m_seen  = 1'b0;
            m_pc    = pc_i;
            mis     = 1'b0;
`ifdef IFU_MISALIGN_EN
            mis = (pc_i[1:0] != 2'b00);
`endif
            if (mis) begin
               m_seen  = 1'b1;
               m_data  = 32'h00000013;
               m_fault = 1'b1;
            end else begin
               m_owed      = 1'b1;
               m_owed_addr = pc_i;
               m_req_id    = m_id;
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // leaves the caller ~2 time units after the edge of the cycle with inst_valid_o
   task automatic wait_inst(input string name, input int unsigned maxc);
      int unsigned c = 0;
      #1;
      while (!inst_valid_o && c < maxc) begin
         step();
         #1;
         c++;
      end
      check(name, {31'd0, inst_valid_o}, 32'd1);
   endtask

   task automatic consume();
      inst_ready_i = 1'b1;
      step();
      inst_ready_i = 1'b0;
   endtask

   initial begin
      int unsigned rc;
      repeat (3) step();
      rst = 1'b0;
      #1;
      check("rst_pc_ready", {31'd0, pc_ready_o}, 32'd1);
      check("rst_req_valid", {31'd0, imem_req_valid_o}, 32'd0);
      check("rst_inst_valid", {31'd0, inst_valid_o}, 32'd0);
      check("rst_inst", inst_o, 32'd0);
      check("rst_inst_pc", inst_pc_o, 32'd0);
      check("rst_fault", {31'd0, inst_fault_o}, 32'd0);
      check("rst_addr", imem_req_addr_o, 32'h80000000);

      // 1: basic fetch, latency N+3
      step();
      mem_lat = 1; imem_req_ready_i = 1'b1;
      pc_i = 32'h80000000; pc_valid_i = 1'b1;
      #1 check("t1_pc_ready", {31'd0, pc_ready_o}, 32'd1);
      step(); pc_valid_i = 1'b0;
      #1 check("t1_req_valid", {31'd0, imem_req_valid_o}, 32'd1);
      check("t1_req_addr", imem_req_addr_o, 32'h80000000);
      step();
      #1 check("t1_no_valid_n2", {31'd0, inst_valid_o}, 32'd0);
      step();
      #1 check("t1_valid_n3", {31'd0, inst_valid_o}, 32'd1);
      check("t1_inst", inst_o, 32'h00100093);
      check("t1_inst_pc", inst_pc_o, 32'h80000000);
      consume();

      // 2: request back-pressure for 3 cycles
      imem_req_ready_i = 1'b0; rc = req_count;
      pc_i = 32'h80000010; pc_valid_i = 1'b1;
      step(); pc_valid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1 check("t2_req_valid", {31'd0, imem_req_valid_o}, 32'd1);
         check("t2_req_addr", imem_req_addr_o, 32'h80000010);
         if (i == 2) imem_req_ready_i = 1'b1;
         step();
      end
      #1 check("t2_req_dropped", {31'd0, imem_req_valid_o}, 32'd0);
      wait_inst("t2_wait", 8);
      check("t2_one_req", req_count, rc + 1);
      check("t2_inst", inst_o, 32'h001000a3);
      consume();

      // 3: flush in WAIT, response two cycles after accept is discarded
      mem_lat = 2;
      pc_i = 32'h80000020; pc_valid_i = 1'b1;
      step(); pc_valid_i = 1'b0;
      step(); flush_i = 1'b1;
      #1 check("t3_pc_ready_wait", {31'd0, pc_ready_o}, 32'd0);
      step(); flush_i = 1'b0;
      #1 check("t3_no_valid_drop", {31'd0, inst_valid_o}, 32'd0);
      step();
      #1 check("t3_idle", {31'd0, pc_ready_o}, 32'd1);
      check("t3_no_valid_idle", {31'd0, inst_valid_o}, 32'd0);
      repeat (2) step();

      // 4: decode stalls 4 cycles, then back-to-back fetch
      mem_lat = 1;
      pc_i = 32'h80000030; pc_valid_i = 1'b1;
      step(); pc_valid_i = 1'b0;
      wait_inst("t4_wait", 8);
      for (int i = 0; i < 4; i++) begin
         check("t4_hold_inst", inst_o, 32'h001000c3);
         check("t4_hold_pc", inst_pc_o, 32'h80000030);
         step();
         #1;
      end
      inst_ready_i = 1'b1; pc_i = 32'h80000004; pc_valid_i = 1'b1;
      #1 check("t4_pc_ready_hs", {31'd0, pc_ready_o}, 32'd1);
      step(); inst_ready_i = 1'b0; pc_valid_i = 1'b0;
      #1 check("t4_b2b_req", {31'd0, imem_req_valid_o}, 32'd1);
      check("t4_b2b_addr", imem_req_addr_o, 32'h80000004);
      wait_inst("t4_wait2", 8);
      check("t4_inst2", inst_o, 32'h00100097);
      check("t4_pc2", inst_pc_o, 32'h80000004);
      consume();

      // 5: flush and ready together in HOLD
      pc_i = 32'h80000040; pc_valid_i = 1'b1;
      step(); pc_valid_i = 1'b0;
      wait_inst("t5_wait", 8);
      flush_i = 1'b1; inst_ready_i = 1'b1;
      step(); flush_i = 1'b0; inst_ready_i = 1'b0;
      #1 check("t5_valid_gone", {31'd0, inst_valid_o}, 32'd0);
      check("t5_pc_ready", {31'd0, pc_ready_o}, 32'd1);

      // flush while the request is still unaccepted: drop must survive until accept
      imem_req_ready_i = 1'b0;
      pc_i = 32'h80000070; pc_valid_i = 1'b1;
      step(); pc_valid_i = 1'b0; flush_i = 1'b1;
      step(); flush_i = 1'b0;
      #1 check("td_req_held", {31'd0, imem_req_valid_o}, 32'd1);
      imem_req_ready_i = 1'b1;
      step();
      #1 check("td_drop_busy", {31'd0, pc_ready_o}, 32'd0);
      step();
      #1 check("td_idle", {31'd0, pc_ready_o}, 32'd1);
      check("td_no_valid", {31'd0, inst_valid_o}, 32'd0);

      // reset in the middle of a fetch
      mem_lat = 3;
      pc_i = 32'h80000050; pc_valid_i = 1'b1;
      step(); pc_valid_i = 1'b0;
      step(); rst = 1'b1;
      step(); rst = 1'b0;
      #1 check("tr_pc_ready", {31'd0, pc_ready_o}, 32'd1);
      check("tr_req_valid", {31'd0, imem_req_valid_o}, 32'd0);
      check("tr_inst", inst_o, 32'd0);
      repeat (4) step();
      mem_lat = 1;
      pc_i = 32'h80000060; pc_valid_i = 1'b1;
      step(); pc_valid_i = 1'b0;
      wait_inst("tr_wait", 8);
      check("tr_inst2", inst_o, 32'h001000f3);
      consume();

`ifdef IFU_MISALIGN_EN
      // 6: misaligned fetch becomes a faulting NOP without a memory request
      rc = req_count;
      pc_i = 32'h80000002; pc_valid_i = 1'b1;
      step(); pc_valid_i = 1'b0;
      #1 check("t6_no_req", {31'd0, imem_req_valid_o}, 32'd0);
      check("t6_valid", {31'd0, inst_valid_o}, 32'd1);
      check("t6_inst", inst_o, 32'h00000013);
      check("t6_fault", {31'd0, inst_fault_o}, 32'd1);
      check("t6_pc", inst_pc_o, 32'h80000002);
      consume();
      check("t6_req_count", req_count, rc);
`endif

      repeat (3) step();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1, "watchdog");
   end

endmodule
